inst_fetch_queue: RTL and testbench

- Dual-issue instruction fetch queue between the fetch stage (I-memory/I-cache response) and the dual decoder.
- Accepts fetch packets of 1 or 2 sequential instructions, buffers them in a circular FIFO, and presents the two oldest as slot A (older) and slot B (younger) with their PCs.
- Supports decoder backpressure and a front-end flush used on branch/jump redirect.

---
 rtl/inst_fetch_queue.sv | 105 ++++++++++
 tb/tb_inst_fetch_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Dual-issue fetch queue: circular buffer of {inst, pc}, FWFT slots A/B from the head.
// Push visible one cycle after its edge; in_ready only when two free entries remain.
module inst_fetch_queue #(
  parameter int          DEPTH    = 8,
  parameter int          PTR_W    = 3,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [1:0]       in_cnt,
  input  logic [31:0]      in_inst0,
  input  logic [31:0]      in_inst1,
  input  logic [31:0]      in_pc,
  output logic             in_ready,
  output logic [31:0]      instA,
  output logic [31:0]      instB,
  output logic [31:0]      pcA,
  output logic [31:0]      pcB,
  output logic             validA,
  output logic             validB,
  input  logic             dec_ready,
  output logic [PTR_W:0]   count
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [PTR_W-1:0] rd_ptr_p1;
  logic [PTR_W-1:0] wr_ptr_p1;
  logic             cnt_legal;
  logic [1:0]       push_n;
  logic [1:0]       pop_n;
  entry_t           head_a;
  entry_t           head_b;

  assign rd_ptr_p1 = rd_ptr_q + PTR_W'(1);
  assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);

  // Acceptance looks only at registered occupancy, so a same-cycle pop never helps.
  assign in_ready  = (count_q <= (PTR_W+1)'(DEPTH - 2));
  assign cnt_legal = (in_cnt == 2'd1) || (in_cnt == 2'd2);
  assign push_n    = (in_valid && in_ready && !flush && cnt_legal) ? in_cnt : 2'd0;

  assign validA = (count_q != '0);
  assign validB = (count_q >= (PTR_W+1)'(2));
  assign pop_n  = dec_ready ? ({1'b0, validA} + {1'b0, validB}) : 2'd0;

  assign head_a = mem_q[rd_ptr_q];
  assign head_b = mem_q[rd_ptr_p1];

  always_comb begin
    instA = NOP_INST;
    pcA   = '0;
    instB = NOP_INST;
    pcB   = '0;
    if (validA) begin
      instA = head_a.inst;
      pcA   = head_a.pc;
    end
    if (validB) begin
      instB = head_b.inst;
      pcB   = head_b.pc;
    end
  end

  assign count = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
    count_d  = count_q + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; push_n is already zero under flush.
  always_ff @(posedge clk) begin
    if (!rst && push_n != 2'd0) begin
      mem_q[wr_ptr_q] <= '{inst: in_inst0, pc: in_pc};
    end
    if (!rst && push_n == 2'd2) begin
      mem_q[wr_ptr_p1] <= '{inst: in_inst1, pc: in_pc + 32'd4};
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: model queue tracks accepted entries and head slots.
module tb_inst_fetch_queue;

  localparam int          DEPTH = 8;
  localparam int          PTR_W = 3;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, dec_ready;
  logic [1:0]  in_cnt;
  logic [31:0] in_inst0, in_inst1, in_pc;
  logic        in_ready, validA, validB;
  logic [31:0] instA, instB, pcA, pcB;
  logic [PTR_W:0] count;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;

  inst_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_cnt(in_cnt),
    .in_inst0(in_inst0), .in_inst1(in_inst1), .in_pc(in_pc), .in_ready(in_ready),
    .instA(instA), .instB(instB), .pcA(pcA), .pcB(pcB),
    .validA(validA), .validB(validB), .dec_ready(dec_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return pc ^ 32'hC0DE0000;
  endfunction

  // Compare head slots against the model, apply this cycle's pop/push/flush, clock, check count.
  task automatic cycle(output bit accepted);
    bit exp_ready;
    int n;
    ent_t e;
    exp_ready = (sb.size() <= DEPTH - 2);
    accepted  = 1'b0;
    check("in_ready", in_ready, exp_ready);
    check("validA", validA, sb.size() >= 1);
    check("validB", validB, sb.size() >= 2);
    if (sb.size() >= 1) begin
      check("instA", instA, sb[0].inst);
      check("pcA", pcA, sb[0].pc);
    end else begin
      check("instA_nop", instA, NOP);
      check("pcA_zero", pcA, 0);
    end
    if (sb.size() >= 2) begin
      check("instB", instB, sb[1].inst);
      check("pcB", pcB, sb[1].pc);
    end else begin
      check("instB_nop", instB, NOP);
      check("pcB_zero", pcB, 0);
    end
    if (flush) begin
      sb.delete();
    end else begin
      if (dec_ready) begin
        n = (sb.size() >= 2) ? 2 : sb.size();
        for (int i = 0; i < n; i++) e = sb.pop_front();
      end
      if (in_valid && exp_ready && (in_cnt == 2'd1 || in_cnt == 2'd2)) begin
        accepted = 1'b1;
        sb.push_back('{inst: in_inst0, pc: in_pc});
        if (in_cnt == 2'd2) sb.push_back('{inst: in_inst1, pc: in_pc + 32'd4});
      end
    end
    @(posedge clk);
    #1;
    check("count", count, sb.size());
  endtask

  task automatic drive(input bit v, input logic [1:0] cnt, input logic [31:0] pc, input bit dr);
    in_valid  = v;
    in_cnt    = cnt;
    in_pc     = pc;
    in_inst0  = mk_inst(pc);
    in_inst1  = mk_inst(pc + 32'd4);
    dec_ready = dr;
  endtask

  task automatic drain();
    bit acc;
    drive(1'b0, 2'd0, 32'h0, 1'b1);
    for (int c = 0; c < 20 && sb.size() > 0; c++) cycle(acc);
    check("drain_empty", count, 0);
  endtask

  initial begin
    bit acc;
    int pushed;
    rst = 1'b1;
    flush = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();

    // Reset then idle
    check("rst_validA", validA, 0);
    check("rst_validB", validB, 0);
    check("rst_instA", instA, 32'h00000013);
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    cycle(acc);

    // Single 2-instruction packet
    drive(1'b1, 2'd2, 32'h100, 1'b0);
    in_inst0 = 32'hAAAA0001;
    in_inst1 = 32'hBBBB0002;
    cycle(acc);
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    check("pkt_validB", validB, 1);
    check("pkt_pcA", pcA, 32'h100);
    check("pkt_pcB", pcB, 32'h104);
    check("pkt_instB", instB, 32'hBBBB0002);
    check("pkt_count", count, 2);
    dec_ready = 1'b1;
    cycle(acc);
    check("pkt_pop_count", count, 0);

    // Illegal in_cnt values push nothing
    drive(1'b1, 2'd3, 32'h50, 1'b0);
    cycle(acc);
    drive(1'b1, 2'd0, 32'h60, 1'b0);
    cycle(acc);
    check("illegal_cnt", count, 0);

    // Odd count: three single-instruction packets
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd1, 32'(i * 4), 1'b0);
      cycle(acc);
    end
    drive(1'b0, 2'd0, 32'h0, 1'b1);
    cycle(acc);
    check("odd_validA", validA, 1);
    check("odd_validB", validB, 0);
    check("odd_pcA", pcA, 32'h8);
    cycle(acc);
    check("odd_count", count, 0);

    // Fill to DEPTH, then a held packet is refused
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd2, 32'h1000 + 32'(i * 8), 1'b0);
      cycle(acc);
      check("fill_accept", acc, 1);
    end
    check("full_count", count, 8);
    check("full_in_ready", in_ready, 0);
    drive(1'b1, 2'd2, 32'h2000, 1'b0);
    cycle(acc);
    check("full_hold_count", count, 8);
    drain();

    // Streaming across pointer wrap with toggling backpressure
    pushed = 0;
    for (int c = 0; c < 100 && pushed < 20; c++) begin
      drive(1'b1, 2'd2, 32'h200 + 32'(pushed * 4), c[0]);
      cycle(acc);
      if (acc) pushed += 2;
    end
    check("wrap_pushed", pushed, 20);
    drain();

    // Flush beats same-cycle push and pop
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'd2, 32'h300 + 32'(i * 8), 1'b0);
      cycle(acc);
    end
    check("pre_flush_count", count, 4);
    drive(1'b1, 2'd2, 32'h380, 1'b1);
    flush = 1'b1;
    cycle(acc);
    flush = 1'b0;
    check("flush_count", count, 0);
    check("flush_validA", validA, 0);
    drive(1'b1, 2'd1, 32'h400, 1'b0);
    cycle(acc);
    check("post_flush_pcA", pcA, 32'h400);
    check("post_flush_validB", validB, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
